pipe_ctrl_sched: RTL and testbench
==================================

Name: pipe_ctrl_sched

Overview:
Pipeline control scheduler that sits downstream of the hazard-resolver FSM (tt_um_fsm_haz) and the memory interface. It arbitrates between three request sources: resolver freeze, resolver flush and memory-busy. It converts the winner into per-stage enable and bubble controls for the 5-stage pipeline plus the PC write enable. It also keeps stall/flush performance counters and runs a stall watchdog.

Parameters:
NSTG, 5, number of pipeline stages; bit 0 = IF … bit NSTG-1 = WB.
FLUSH_CYC, 2, cycles the front stages are bubbled per flush; legal range 1..7.
MAX_STALL, 15, consecutive hazard-stall cycles before the watchdog fires; legal range 1..255.
CNT_W, 8, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
freeze_req  in  1  hazard resolver pc_freeze.
flush_req  in  1  hazard resolver do_flush; level signal.
resolved  in  1  hazard resolver resolved.
mem_busy  in  1  data memory not ready.
clr_cnt  in  1  synchronous clear of the performance counters.
stg_en  out  NSTG  per-stage register enable.
stg_bubble  out  NSTG  per-stage NOP insert.
pc_we  out  1  PC register write enable.
state  out  2  current state: 0 RUN, 1 HSTALL, 2 MSTALL, 3 FLUSH.
stall_cnt  out  CNT_W  total stall cycles, HSTALL plus MSTALL; saturating.
flush_cnt  out  CNT_W  flush entries; wraps.
timeout  out  1  one-cycle watchdog pulse.

Behaviour:
- Moore machine. All outputs are registered and decoded from the state register. A request sampled at edge N changes the outputs after edge N, so latency is 1 cycle.
- Reset (async, rst_n=0):
  - state=RUN, stg_en all 1, stg_bubble=0, pc_we=1.
  - Both counters 0, timeout=0, pend_flush=0, stall timer 0.
  - Reset mid-operation discards any pending flush or stall.
- Priority from RUN: mem_busy > flush_req > freeze_req.
  - RUN -> MSTALL if mem_busy.
  - RUN -> FLUSH if flush_req.
  - RUN -> HSTALL if freeze_req && !resolved.
  - Otherwise stay in RUN.
- RUN outputs: stg_en all 1, stg_bubble 0, pc_we 1.
- HSTALL outputs: stg_en[1:0]=0, all other stg_en bits 1, stg_bubble[2]=1 (bubble into EX), pc_we=0.
- HSTALL exits:
  - -> MSTALL if mem_busy.
  - -> FLUSH if flush_req.
  - -> RUN if !freeze_req or resolved.
  - Timer counts consecutive HSTALL cycles. When it reaches MAX_STALL: timeout=1 for one cycle and forced -> RUN, regardless of freeze_req.
  - The timer clears on any exit from HSTALL.
- MSTALL outputs: stg_en all 0, stg_bubble 0, pc_we 0.
  - flush_req seen in MSTALL sets pend_flush; the flush is deferred, not dropped.
  - When mem_busy=0: -> FLUSH if pend_flush or flush_req; else -> HSTALL if freeze_req && !resolved; else -> RUN.
- FLUSH outputs: stg_en all 1, stg_bubble[1:0]=2'b11, pc_we=1 (redirect target loads).
  - Lasts exactly FLUSH_CYC cycles; the flush_req level is ignored while in FLUSH.
  - mem_busy during FLUSH -> MSTALL. The remaining flush cycles are kept by setting pend_flush, and a fresh FLUSH_CYC window restarts afterwards.
  - At the end of the window, re-evaluate with RUN priority. If flush_req is still high, re-enter FLUSH (back-to-back flush, counted again).
  - pend_flush clears on FLUSH entry.
- Counters:
  - stall_cnt increments in every cycle where state is HSTALL or MSTALL, and saturates at all-ones.
  - flush_cnt increments on every entry into FLUSH and wraps modulo 2^CNT_W.
  - clr_cnt zeroes both counters next cycle and has priority over increment in the same cycle.
- state encoding is fixed as listed in Ports; software reads it.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum (RUN/HSTALL/MSTALL/FLUSH with the fixed encodings).
  - Stage index constants IF=0, ID=1, EX=2, MEM=3, WB=4.
  - Output-decode constant vectors per state.
- One natural sub-module: perf_counter (CNT_W, sat/wrap mode select, inc, clr), instantiated twice.

Test Plan:
- Reset, then idle with all inputs 0 for 3 cycles -> state=0, stg_en=5'b11111, stg_bubble=0, pc_we=1, counters 0.
- freeze_req=1, resolved=0 for 4 cycles, then resolved=1 -> state=1 for 4 cycles, stg_en=5'b11100, stg_bubble=5'b00100, pc_we=0; back to RUN one cycle after resolved; stall_cnt=4.
- flush_req=1 for 1 cycle -> FLUSH for exactly 2 cycles with stg_bubble=5'b00011, pc_we=1; flush_cnt=1; then RUN.
- mem_busy=1 for 3 cycles with a 1-cycle flush_req pulse in the middle -> stg_en=0 for 3 cycles, then FLUSH for 2 cycles; flush_cnt increments by 1.
- freeze_req held high with resolved=0 for 20 cycles -> timeout pulses exactly once at HSTALL cycle 15, state returns to 0, then re-enters HSTALL next cycle; stall_cnt saturates at 255 under a long soak.
- Assert rst_n=0 mid-FLUSH with clr_cnt=1 and flush_req=1 in the same window -> outputs return to reset values asynchronously and no pending flush survives release.

Source files
------------

// File: rtl/pipe_ctrl_sched_pkg.sv
// Shared types and per-state control decode for the pipeline control scheduler.
package pipe_ctrl_pkg;

  localparam int unsigned NSTG  = 5;
  localparam int unsigned TMR_W = 8;
  localparam int unsigned FL_W  = 3;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

  // Encoding is software visible through the state port.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HSTALL = 2'd1,
    MSTALL = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  typedef struct packed {
    logic [NSTG-1:0] stg_en;
    logic [NSTG-1:0] stg_bubble;
    logic            pc_we;
  } stg_ctrl_t;

  localparam logic [NSTG-1:0] EN_ALL     = '1;
  localparam logic [NSTG-1:0] EN_NONE    = '0;
  localparam logic [NSTG-1:0] EN_HSTALL  = ~((NSTG'(1) << STG_IF) | (NSTG'(1) << STG_ID));
  localparam logic [NSTG-1:0] BUB_NONE   = '0;
  localparam logic [NSTG-1:0] BUB_HSTALL = NSTG'(1) << STG_EX;
  localparam logic [NSTG-1:0] BUB_FLUSH  = (NSTG'(1) << STG_IF) | (NSTG'(1) << STG_ID);

  localparam stg_ctrl_t CTRL_RUN    = '{stg_en: EN_ALL,    stg_bubble: BUB_NONE,   pc_we: 1'b1};
  localparam stg_ctrl_t CTRL_HSTALL = '{stg_en: EN_HSTALL, stg_bubble: BUB_HSTALL, pc_we: 1'b0};
  localparam stg_ctrl_t CTRL_MSTALL = '{stg_en: EN_NONE,   stg_bubble: BUB_NONE,   pc_we: 1'b0};
  localparam stg_ctrl_t CTRL_FLUSH  = '{stg_en: EN_ALL,    stg_bubble: BUB_FLUSH,  pc_we: 1'b1};

  function automatic stg_ctrl_t ctrl_of(state_e s);
    stg_ctrl_t c;
    case (s)
      HSTALL:  c = CTRL_HSTALL;
      MSTALL:  c = CTRL_MSTALL;
      FLUSH:   c = CTRL_FLUSH;
      default: c = CTRL_RUN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sched_if.sv
// Request/control bundle between the hazard resolver, memory side and pipeline.
interface pipe_ctrl_sched_if #(
  parameter int unsigned CNT_W = 8
) ();
  import pipe_ctrl_pkg::*;

  logic             freeze_req;
  logic             flush_req;
  logic             resolved;
  logic             mem_busy;
  logic             clr_cnt;
  logic [NSTG-1:0]  stg_en;
  logic [NSTG-1:0]  stg_bubble;
  logic             pc_we;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             timeout;

  modport master (
    output freeze_req, flush_req, resolved, mem_busy, clr_cnt,
    input  stg_en, stg_bubble, pc_we, state, stall_cnt, flush_cnt, timeout
  );

  modport slave (
    input  freeze_req, flush_req, resolved, mem_busy, clr_cnt,
    output stg_en, stg_bubble, pc_we, state, stall_cnt, flush_cnt, timeout
  );

endinterface

// File: rtl/pipe_ctrl_sched_perf_counter.sv
// Performance counter with synchronous clear and selectable saturate/wrap.
module perf_counter #(
  parameter int unsigned CNT_W = 8,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(SAT && (&cnt))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl_sched.sv
// Arbitrates memory-busy, flush and freeze requests into registered pipeline
// stage enables/bubbles, with stall/flush counters and a hazard-stall watchdog.
module pipe_ctrl_sched
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned MAX_STALL = 15,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_ctrl_sched_if.slave bus
);

  state_e           state_q, state_d, run_pick;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [FL_W-1:0]  fl_q, fl_d;
  logic             pend_q, pend_d;
  logic             timeout_q, timeout_d;
  logic             want_hs, win_end, flush_entry, stall_inc;
  stg_ctrl_t        ctrl_q, ctrl_d;

  assign want_hs  = bus.freeze_req && !bus.resolved;
  assign win_end  = (fl_q == FL_W'(FLUSH_CYC - 1));
  assign run_pick = bus.mem_busy  ? MSTALL :
                    bus.flush_req ? FLUSH  :
                    want_hs       ? HSTALL : RUN;

  // State register; stage controls are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      tmr_q     <= '0;
      fl_q      <= '0;
      pend_q    <= 1'b0;
      timeout_q <= 1'b0;
      ctrl_q    <= CTRL_RUN;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      fl_q      <= fl_d;
      pend_q    <= pend_d;
      timeout_q <= timeout_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Next-state, pending-flush, watchdog and flush-window bookkeeping.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    timeout_d   = 1'b0;
    flush_entry = 1'b0;
    tmr_d       = '0;
    fl_d        = '0;

    case (state_q)
      RUN: state_d = run_pick;
      HSTALL: begin
        if (bus.mem_busy) begin
          state_d = MSTALL;
        end else if (bus.flush_req) begin
          state_d = FLUSH;
        end else if (!want_hs) begin
          state_d = RUN;
        end else if (tmr_q == TMR_W'(MAX_STALL - 1)) begin
          state_d   = RUN;
          timeout_d = 1'b1;
        end
      end
      MSTALL: begin
        if (bus.flush_req) begin
          pend_d = 1'b1;
        end
        if (!bus.mem_busy) begin
          if (pend_q || bus.flush_req) begin
            state_d = FLUSH;
          end else if (want_hs) begin
            state_d = HSTALL;
          end else begin
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        // Mid-window memory stall keeps the flush owed; window end re-arbitrates.
        if (win_end) begin
          state_d = run_pick;
        end else if (bus.mem_busy) begin
          state_d = MSTALL;
          pend_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    flush_entry = (state_d == FLUSH) && ((state_q != FLUSH) || win_end);
    if (flush_entry) begin
      pend_d = 1'b0;
    end
    if ((state_q == HSTALL) && (state_d == HSTALL)) begin
      tmr_d = TMR_W'(tmr_q + 1'b1);
    end
    if ((state_d == FLUSH) && !flush_entry) begin
      fl_d = FL_W'(fl_q + 1'b1);
    end
  end

  // Output decode of the upcoming state.
  always_comb begin
    ctrl_d = CTRL_RUN;
    ctrl_d = ctrl_of(state_d);
  end

  assign stall_inc = (state_q == HSTALL) || (state_q == MSTALL);

  perf_counter #(.CNT_W(CNT_W), .SAT(1'b1)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (bus.clr_cnt),
    .cnt   (bus.stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W), .SAT(1'b0)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_entry),
    .clr   (bus.clr_cnt),
    .cnt   (bus.flush_cnt)
  );

  assign bus.stg_en     = ctrl_q.stg_en;
  assign bus.stg_bubble = ctrl_q.stg_bubble;
  assign bus.pc_we      = ctrl_q.pc_we;
  assign bus.state      = 2'(state_q);
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl_sched.sv
// Self-checking bench for pipe_ctrl_sched: directed table, corner sequences, random vs model.
module tb_pipe_ctrl_sched;

  localparam int FLUSH_CYC = 2;
  localparam int MAX_STALL = 15;
  localparam int CNT_MAX   = 255;

  bit   clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_sched_if #(.CNT_W(8)) bus ();

  pipe_ctrl_sched #(.FLUSH_CYC(FLUSH_CYC), .MAX_STALL(MAX_STALL), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected stage controls indexed by state number (RUN, HSTALL, MSTALL, FLUSH).
  logic [4:0] exp_en  [4] = '{5'b11111, 5'b11100, 5'b00000, 5'b11111};
  logic [4:0] exp_bub [4] = '{5'b00000, 5'b00100, 5'b00000, 5'b00011};
  logic       exp_pc  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Reference model: age = HSTALL cycles so far, left = flush cycles remaining.
  int m_state, m_age, m_left, m_stall, m_flush;
  bit m_pend, m_to;

  typedef struct {
    bit fz, fl, rs, mb, cc;
    int st, sc, fc;
    bit to;
  } vec_t;
  vec_t tbl[$];

  task automatic model_reset();
    m_state = 0; m_age = 0; m_left = 0; m_stall = 0; m_flush = 0;
    m_pend = 1'b0; m_to = 1'b0;
  endtask

  function automatic int run_pick(bit mb, bit fl, bit want);
    if (mb) return 2;
    if (fl) return 3;
    if (want) return 1;
    return 0;
  endfunction

  task automatic model_step(bit fz, bit fl, bit rs, bit mb, bit cc);
    int nx;
    bit fresh, want, pend;
    want = fz && !rs;
    pend = m_pend;
    m_to = 1'b0;
    case (m_state)
      0: nx = run_pick(mb, fl, want);
      1: begin
        if (mb) nx = 2;
        else if (fl) nx = 3;
        else if (!want) nx = 0;
        else if (m_age >= MAX_STALL) begin nx = 0; m_to = 1'b1; end
        else nx = 1;
      end
      2: begin
        if (fl) pend = 1'b1;
        nx = mb ? 2 : (pend ? 3 : (want ? 1 : 0));
      end
      default: begin
        if (m_left == 1) nx = run_pick(mb, fl, want);
        else if (mb) begin nx = 2; pend = 1'b1; end
        else nx = 3;
      end
    endcase
    fresh = (nx == 3) && (m_state != 3 || m_left == 1);
    if (cc) m_stall = 0;
    else if (m_state == 1 || m_state == 2) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
    if (cc) m_flush = 0;
    else if (fresh) m_flush = (m_flush + 1) % 256;
    m_age  = (nx == 1) ? ((m_state == 1) ? m_age + 1 : 1) : 0;
    m_left = (nx == 3) ? (fresh ? FLUSH_CYC : m_left - 1) : 0;
    if (fresh) pend = 1'b0;
    m_pend  = pend;
    m_state = nx;
  endtask

  task automatic drive(bit fz, bit fl, bit rs, bit mb, bit cc);
    bus.freeze_req = fz;
    bus.flush_req  = fl;
    bus.resolved   = rs;
    bus.mem_busy   = mb;
    bus.clr_cnt    = cc;
  endtask

  // One clock: drive, clock edge, advance model, settle past the edge.
  task automatic step(bit fz, bit fl, bit rs, bit mb, bit cc);
    drive(fz, fl, rs, mb, cc);
    @(posedge clk);
    model_step(fz, fl, rs, mb, cc);
    #1;
  endtask

  task automatic check(string name, int st, int sc, int fc, bit to);
    n_vec++;
    if (bus.state !== 2'(st) || bus.stg_en !== exp_en[st] || bus.stg_bubble !== exp_bub[st] ||
        bus.pc_we !== exp_pc[st] || bus.stall_cnt !== 8'(sc) || bus.flush_cnt !== 8'(fc) ||
        bus.timeout !== to) begin
      n_err++;
      $display("FAIL %s @%0t: got st=%0d en=%b bub=%b pc=%b sc=%0d fc=%0d to=%b, want st=%0d en=%b bub=%b pc=%b sc=%0d fc=%0d to=%b",
               name, $time, bus.state, bus.stg_en, bus.stg_bubble, bus.pc_we, bus.stall_cnt,
               bus.flush_cnt, bus.timeout, st, exp_en[st], exp_bub[st], exp_pc[st], sc, fc, to);
    end
  endtask

  task automatic check_val(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  task automatic add(bit fz, bit fl, bit rs, bit mb, bit cc, int st, int sc, int fc);
    vec_t v;
    v.fz = fz; v.fl = fl; v.rs = rs; v.mb = mb; v.cc = cc;
    v.st = st; v.sc = sc; v.fc = fc; v.to = 1'b0;
    tbl.push_back(v);
  endtask

  initial begin
    int prev, sc, st;
    bit to;

    drive(0, 0, 0, 0, 0);
    model_reset();
    #12 rst_n = 1'b1;
    check("reset", 0, 0, 0, 0);

    //   fz fl rs mb cc   st sc fc
    add(0, 0, 0, 0, 0,   0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0);   // freeze: hazard stall
    add(1, 0, 0, 0, 0,   1, 1, 0);
    add(1, 0, 0, 0, 0,   1, 2, 0);
    add(1, 0, 0, 0, 0,   1, 3, 0);
    add(1, 0, 1, 0, 0,   0, 4, 0);   // resolved
    add(0, 1, 0, 0, 0,   3, 4, 1);   // single flush pulse
    add(0, 0, 0, 0, 0,   3, 4, 1);
    add(0, 0, 0, 0, 0,   0, 4, 1);
    add(0, 0, 0, 1, 0,   2, 4, 1);   // memory stall with deferred flush
    add(0, 1, 0, 1, 0,   2, 5, 1);
    add(0, 0, 0, 1, 0,   2, 6, 1);
    add(0, 0, 0, 0, 0,   3, 7, 2);
    add(0, 0, 0, 0, 0,   3, 7, 2);
    add(0, 0, 0, 0, 0,   0, 7, 2);
    add(0, 0, 0, 0, 1,   0, 0, 0);   // clear
    add(0, 0, 0, 0, 0,   0, 0, 0);
    add(0, 1, 0, 0, 0,   3, 0, 1);   // memory stall interrupts flush window
    add(0, 0, 0, 1, 0,   2, 0, 1);
    add(0, 0, 0, 0, 0,   3, 1, 2);
    add(0, 0, 0, 0, 0,   3, 1, 2);
    add(0, 0, 0, 0, 0,   0, 1, 2);
    add(0, 1, 0, 0, 0,   3, 1, 3);   // held flush: back-to-back windows
    add(0, 1, 0, 0, 0,   3, 1, 3);
    add(0, 1, 0, 0, 0,   3, 1, 4);
    add(0, 0, 0, 0, 0,   3, 1, 4);
    add(0, 0, 0, 0, 0,   0, 1, 4);
    add(1, 0, 0, 0, 0,   1, 1, 4);   // clear beats increment
    add(1, 0, 0, 0, 1,   1, 0, 0);
    add(0, 0, 0, 0, 0,   0, 1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].fz, tbl[i].fl, tbl[i].rs, tbl[i].mb, tbl[i].cc);
      check($sformatf("tbl%0d", i), tbl[i].st, tbl[i].sc, tbl[i].fc, tbl[i].to);
    end

    // Watchdog: 15 hazard-stall cycles, forced RUN with pulse, then re-entry.
    step(0, 0, 0, 0, 1);
    check("wd_clr", 0, 0, 0, 0);
    prev = 0;
    sc = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 0, 0, 0);
      if (prev == 1) sc++;
      st = (i == MAX_STALL + 1) ? 0 : 1;
      to = (i == MAX_STALL + 1);
      check($sformatf("wd%0d", i), st, sc, 0, to);
      prev = st;
    end
    for (int i = 0; i < 300; i++) step(1, 0, 0, 0, 0);
    check_val("stall_sat", int'(bus.stall_cnt), CNT_MAX);
    check_val("stall_sat_model", int'(bus.stall_cnt), m_stall);

    // Asynchronous reset in the middle of a flush window.
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    check("pre_rst_flush", 3, 0, 1, 0);
    #2;
    drive(0, 1, 0, 0, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_flush", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      check($sformatf("post_rst%0d", i), 0, 0, 0, 0);
    end

    // Reset while a deferred flush is pending in a memory stall.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    check("pend_set", 2, 1, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_pend", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    check("no_pend_flush", 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("no_pend_flush2", 0, 0, 0, 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bit fz, fl, rs, mb, cc;
      fz = ($urandom_range(99) < 50);
      fl = ($urandom_range(99) < 12);
      rs = ($urandom_range(99) < 25);
      mb = ($urandom_range(99) < 20);
      cc = ($urandom_range(99) < 2);
      step(fz, fl, rs, mb, cc);
      check("rand", m_state, m_stall, m_flush, m_to);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
